// File: rtl/fetch_buffer_pkg.sv
// Shared types and helpers for the fetch buffer. N_WAY, XLEN and INST normally come
// from the global headers; fallbacks keep this slice self-contained.
`ifndef N_WAY
`define N_WAY 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST
`define INST 32
`endif

package fetch_buffer_pkg;

    localparam int NW       = `N_WAY;
    localparam int XW       = `XLEN;
    localparam int IW       = `INST;
    localparam int FB_DEPTH = 8;
    localparam int FB_PTR_W = $clog2(FB_DEPTH) + 1;
    localparam int TAKE_W   = $clog2(NW + 1);

    typedef struct packed {
        logic [XW-1:0] pc;
        logic [IW-1:0] inst;
    } FETCH_ENTRY;

    localparam int ENTRY_W = $bits(FETCH_ENTRY);

    function automatic logic [TAKE_W-1:0] popcount(input logic [NW-1:0] v);
        logic [TAKE_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < NW; i++) n = n + TAKE_W'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/fetch_buffer_ram.sv
// Fetch buffer storage: N_WAY write ports, N_WAY combinational read ports starting at
// the head index. Data array is deliberately not reset.
module fetch_buffer_ram
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH
) (
    input  logic                              clock,
    input  logic [NW-1:0]                     we,
    input  logic [NW*$clog2(DEPTH)-1:0]       waddr,
    input  logic [NW*ENTRY_W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0]          rhead,
    output logic [NW*ENTRY_W-1:0]             rdata
);

    localparam int IDX_W = $clog2(DEPTH);

    FETCH_ENTRY mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < NW; i++) begin
            if (we[i]) mem[waddr[i*IDX_W +: IDX_W]] <= FETCH_ENTRY'(wdata[i*ENTRY_W +: ENTRY_W]);
        end
    end

    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            rdata[i*ENTRY_W +: ENTRY_W] = mem[IDX_W'(rhead + IDX_W'(i))];
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// Circular fetch-to-decode instruction queue with single-cycle flush.
// Optional same-cycle bypass when empty: define FETCH_BUF_BYPASS_EN.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [NW-1:0]                 fetch_valid,
    input  logic [NW*XW-1:0]              fetch_PC,
    input  logic [NW*IW-1:0]              fetch_inst,
    output logic                          fetch_ready,
    input  logic [TAKE_W-1:0]             dec_take,
    output logic [NW*XW-1:0]              out_PC,
    output logic [NW*IW-1:0]              out_inst,
    output logic [NW-1:0]                 out_valid,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0]       occ;
    logic [TAKE_W-1:0]      nv, avail, take, skip, enq, deq;
    logic                   byp;
    logic [NW-1:0]          we;
    logic [NW*IDX_W-1:0]    waddr;
    logic [NW*ENTRY_W-1:0]  wdata, rdata;

    // Wrap bits make tail - head the exact occupancy, full or empty.
    assign occ         = tail_q - head_q;
    assign count       = CNT_W'(occ);
    assign fetch_ready = (PTR_W'(DEPTH) - occ) >= PTR_W'(NW);

    always_comb begin
        FETCH_ENTRY  rd_e;
        int unsigned src;
        rd_e  = '0;
        src   = 0;
        nv    = popcount(fetch_valid);
`ifdef FETCH_BUF_BYPASS_EN
        byp   = (occ == '0) && fetch_ready && !flush;
`else
        byp   = 1'b0;
`endif
        if (byp)                        avail = nv;
        else if (occ >= PTR_W'(NW))     avail = TAKE_W'(NW);
        else                            avail = occ[TAKE_W-1:0];
        take  = (dec_take > avail) ? avail : dec_take;
        // Bypassed lanes consumed this cycle never reach storage; the rest pack down.
        skip  = byp ? take : '0;
        enq   = fetch_ready ? (nv - skip) : '0;
        deq   = byp ? '0 : take;

        we    = '0;
        waddr = '0;
        wdata = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            src = i + 32'(skip);
            waddr[i*IDX_W +: IDX_W] = IDX_W'(tail_q + PTR_W'(i));
            if (src < 32'(nv)) begin
                we[i] = fetch_ready && !flush;
                wdata[i*ENTRY_W +: ENTRY_W] = {fetch_PC[src*XW +: XW], fetch_inst[src*IW +: IW]};
            end
        end

        out_valid = '0;
        out_PC    = '0;
        out_inst  = '0;
        for (int unsigned i = 0; i < NW; i++) begin
            out_valid[i] = TAKE_W'(i) < avail;
            if (out_valid[i]) begin
                if (byp) begin
                    out_PC[i*XW +: XW]   = fetch_PC[i*XW +: XW];
                    out_inst[i*IW +: IW] = fetch_inst[i*IW +: IW];
                end else begin
                    rd_e = FETCH_ENTRY'(rdata[i*ENTRY_W +: ENTRY_W]);
                    out_PC[i*XW +: XW]   = rd_e.pc;
                    out_inst[i*IW +: IW] = rd_e.inst;
                end
            end
        end

        head_d = flush ? '0 : head_q + PTR_W'(deq);
        tail_d = flush ? '0 : tail_q + PTR_W'(enq);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    fetch_buffer_ram #(.DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rhead (head_q[IDX_W-1:0]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer against a queue-based reference model.
module tb_fetch_buffer;
    import fetch_buffer_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic                  flush = 1'b0;
    logic [NW-1:0]         fetch_valid = '0;
    logic [NW*XW-1:0]      fetch_PC = '0;
    logic [NW*IW-1:0]      fetch_inst = '0;
    logic                  fetch_ready;
    logic [TAKE_W-1:0]     dec_take = '0;
    logic [NW*XW-1:0]      out_PC;
    logic [NW*IW-1:0]      out_inst;
    logic [NW-1:0]         out_valid;
    logic [CNT_W-1:0]      count;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_PC(fetch_PC), .fetch_inst(fetch_inst),
        .fetch_ready(fetch_ready), .dec_take(dec_take),
        .out_PC(out_PC), .out_inst(out_inst), .out_valid(out_valid), .count(count)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset && ((fetch_valid & NW'(fetch_valid + 1'b1)) != '0))
            $error("fetch_valid not thermometer coded: %b", fetch_valid);
    end

    int checks = 0;
    int errors = 0;

    FETCH_ENTRY        mq[$];
    logic [NW-1:0]     exp_valid;
    logic [NW*XW-1:0]  exp_pc;
    logic [NW*IW-1:0]  exp_inst;
    int                exp_count, exp_take, in_nv;
    logic              exp_ready, exp_byp;

    function automatic FETCH_ENTRY lane(input int i);
        FETCH_ENTRY e;
        e.pc   = fetch_PC[i*XW +: XW];
        e.inst = fetch_inst[i*IW +: IW];
        return e;
    endfunction

    // Expected outputs from queue contents and current inputs.
    function automatic void compute_exp();
        int n, shown;
        FETCH_ENTRY e;
        n = mq.size();
        in_nv = 0;
        for (int i = 0; i < NW; i++) if (fetch_valid[i]) in_nv++;
        exp_count = n;
        exp_ready = (DEPTH - n) >= NW;
        exp_byp = 1'b0;
`ifdef FETCH_BUF_BYPASS_EN
        exp_byp = (n == 0) && !flush;
`endif
        shown = exp_byp ? in_nv : ((n < NW) ? n : NW);
        exp_valid = '0; exp_pc = '0; exp_inst = '0;
        for (int i = 0; i < shown; i++) begin
            e = exp_byp ? lane(i) : mq[i];
            exp_valid[i] = 1'b1;
            exp_pc[i*XW +: XW] = e.pc;
            exp_inst[i*IW +: IW] = e.inst;
        end
        exp_take = (int'(dec_take) < shown) ? int'(dec_take) : shown;
    endfunction

    task automatic set_inputs(input int nv, input logic [XW-1:0] pc0, input int take, input logic fl);
        for (int i = 0; i < NW; i++) begin
            fetch_valid[i] = (i < nv);
            fetch_PC[i*XW +: XW] = pc0 + XW'(4 * i);
            fetch_inst[i*IW +: IW] = IW'($urandom);
        end
        dec_take = TAKE_W'(take);
        flush = fl;
        #1;
    endtask

    task automatic advance();
        compute_exp();
        @(posedge clock);
        if (flush) mq.delete();
        else if (exp_byp) begin
            for (int i = exp_take; i < in_nv; i++) mq.push_back(lane(i));
        end else begin
            for (int i = 0; i < exp_take; i++) void'(mq.pop_front());
            if (exp_ready) for (int i = 0; i < in_nv; i++) mq.push_back(lane(i));
        end
        #1;
    endtask

    task automatic do_flush();
        set_inputs(0, '0, 0, 1'b1);
        advance();
        set_inputs(0, '0, 0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mq.delete();
        #3;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (out_valid !== '0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", fetch_ready); end
        checks++; if (out_PC !== '0) begin errors++; $display("FAIL reset_pc got %h want 0", out_PC); end
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_basic();
        do_flush();
        set_inputs(2, 32'h100, 0, 1'b0);
        advance();
        set_inputs(0, '0, 0, 1'b0);
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL basic_valid got %b want 11", out_valid); end
        checks++; if (out_PC[0 +: XW] !== 32'h100) begin errors++; $display("FAIL basic_pc0 got %h want 100", out_PC[0 +: XW]); end
        checks++; if (out_PC[XW +: XW] !== 32'h104) begin errors++; $display("FAIL basic_pc1 got %h want 104", out_PC[XW +: XW]); end
        checks++; if (int'(count) !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", count); end
        compute_exp();
        checks++; if (out_inst !== exp_inst) begin errors++; $display("FAIL basic_inst got %h want %h", out_inst, exp_inst); end
    endtask

    task automatic test_fill();
        do_flush();
        for (int g = 0; g < 4; g++) begin
            set_inputs(2, XW'(8 * g), 0, 1'b0);
            checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_g%0d got %b want 1", g, fetch_ready); end
            advance();
        end
        set_inputs(2, 32'h20, 1, 1'b0);
        checks++; if (int'(count) !== 8) begin errors++; $display("FAIL fill_count got %0d want 8", count); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got %b want 0", fetch_ready); end
        checks++; if (out_valid !== 2'b11) begin errors++; $display("FAIL fill_valid_full got %b want 11", out_valid); end
        checks++; if (out_PC[0 +: XW] !== 32'h0) begin errors++; $display("FAIL fill_pc0_full got %h want 0", out_PC[0 +: XW]); end
        advance();
        set_inputs(2, 32'h20, 1, 1'b0);
        checks++; if (out_PC[0 +: XW] !== 32'h4) begin errors++; $display("FAIL fill_pc0_after_take got %h want 4", out_PC[0 +: XW]); end
        checks++; if (int'(count) !== 7 || fetch_ready !== 1'b0) begin errors++; $display("FAIL fill_count7 got %0d/%b want 7/0", count, fetch_ready); end
        advance();
        set_inputs(0, '0, 0, 1'b0);
        checks++; if (int'(count) !== 6 || fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_count6 got %0d/%b want 6/1", count, fetch_ready); end
    endtask

    task automatic test_wrap();
        logic [XW-1:0] pc_exp;
        do_flush();
        set_inputs(2, 32'h1000, 0, 1'b0);
        advance();
        pc_exp = 32'h1000;
        for (int k = 0; k < 20; k++) begin
            set_inputs(2, XW'(32'h1008 + 8 * k), 2, 1'b0);
            checks++;
            if (out_PC[0 +: XW] !== pc_exp || out_PC[XW +: XW] !== pc_exp + 4 || int'(count) !== 2) begin
                errors++;
                $display("FAIL wrap_k%0d got pc %h/%h cnt %0d want %h/%h cnt 2",
                         k, out_PC[0 +: XW], out_PC[XW +: XW], count, pc_exp, pc_exp + 4);
            end
            advance();
            pc_exp = pc_exp + 8;
        end
    endtask

    task automatic test_clamp();
        do_flush();
        set_inputs(1, 32'h300, 0, 1'b0);
        advance();
        set_inputs(0, '0, 2, 1'b0);
        checks++; if (out_valid !== 2'b01) begin errors++; $display("FAIL clamp_valid got %b want 01", out_valid); end
        advance();
        checks++; if (int'(count) !== 0) begin errors++; $display("FAIL clamp_count got %0d want 0", count); end
        advance();
        checks++; if (int'(count) !== 0 || out_valid !== '0) begin errors++; $display("FAIL clamp_empty_take got %0d/%b want 0/0", count, out_valid); end
        set_inputs(0, '0, 0, 1'b0);
    endtask

    task automatic test_flush();
        do_flush();
        set_inputs(2, 32'h400, 0, 1'b0); advance();
        set_inputs(2, 32'h408, 0, 1'b0); advance();
        set_inputs(1, 32'h410, 0, 1'b0); advance();
        set_inputs(2, 32'h414, 2, 1'b1);
        checks++; if (int'(count) !== 5) begin errors++; $display("FAIL flush_pre_count got %0d want 5", count); end
        checks++; if (out_valid !== 2'b11 || out_PC[0 +: XW] !== 32'h400) begin errors++; $display("FAIL flush_cycle_out got %b/%h want 11/400", out_valid, out_PC[0 +: XW]); end
        advance();
        set_inputs(0, '0, 0, 1'b0);
        checks++; if (int'(count) !== 0) begin errors++; $display("FAIL flush_count got %0d want 0", count); end
        checks++; if (out_valid !== '0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL flush_state got %b/%b want 00/1", out_valid, fetch_ready); end
    endtask

`ifdef FETCH_BUF_BYPASS_EN
    task automatic test_bypass();
        do_flush();
        set_inputs(2, 32'h200, 1, 1'b0);
        checks++; if (out_valid[0] !== 1'b1 || out_PC[0 +: XW] !== 32'h200) begin errors++; $display("FAIL bypass_same got %b/%h want 1/200", out_valid[0], out_PC[0 +: XW]); end
        advance();
        set_inputs(0, '0, 0, 1'b0);
        checks++; if (int'(count) !== 1 || out_PC[0 +: XW] !== 32'h204) begin errors++; $display("FAIL bypass_next got %0d/%h want 1/204", count, out_PC[0 +: XW]); end
    endtask
`endif

    task automatic test_random();
        int nv, tk;
        do_flush();
        for (int c = 0; c < 400; c++) begin
            nv = $urandom_range(0, NW);
            tk = ((c / 50) % 2 == 0) ? $urandom_range(0, 1) : $urandom_range(0, NW);
            set_inputs(nv, XW'($urandom), tk, ($urandom_range(0, 31) == 0));
            compute_exp();
            checks++;
            if (out_valid !== exp_valid || out_PC !== exp_pc || out_inst !== exp_inst ||
                int'(count) !== exp_count || fetch_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_c%0d got v%b pc%h cnt%0d rdy%b want v%b pc%h cnt%0d rdy%b",
                         c, out_valid, out_PC, count, fetch_ready, exp_valid, exp_pc, exp_count, exp_ready);
            end
            advance();
        end
    endtask

    task automatic test_reset_mid();
        do_flush();
        set_inputs(2, 32'h500, 0, 1'b0); advance();
        set_inputs(2, 32'h508, 1, 1'b1);
        #2;
        reset = 1'b0;
        mq.delete();
        #1;
        checks++; if (count !== '0 || out_valid !== '0 || fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_mid got %0d/%b/%b want 0/00/1", count, out_valid, fetch_ready); end
        set_inputs(0, '0, 0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_clamp();
        test_flush();
`ifdef FETCH_BUF_BYPASS_EN
        test_bypass();
`endif
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
